// File: rtl/mux_rr_arbiter.sv
// Two-channel FIFO-buffered round-robin feeder for a 2:1 mux; pushed word visible one edge later.
// Output register stalls (din_*, sel, valid_out, FIFO heads hold) while valid_out=1 and ready_out=0.

module mux_rr_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    // A push into a full FIFO is dropped even if the same edge pops.
    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_wr   = i_push && !w_full;
    assign w_rd   = i_pop && (r_cnt != '0);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_rd) r_rp <= r_rp + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_dat;
    end

    assign o_head = r_mem[r_rp];
    assign o_cnt  = r_cnt;
endmodule

module mux_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push_0,
    input  logic [WIDTH-1:0] data_in_0,
    input  logic             push_1,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic             ready_out,
    output logic             full_0,
    output logic             full_1,
    output logic             err_0,
    output logic             err_1,
    output logic [WIDTH-1:0] din_0,
    output logic [WIDTH-1:0] din_1,
    output logic             sel,
    output logic             valid_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_din_0;
    logic [WIDTH-1:0] r_din_1;
    logic             r_sel;
    logic             r_valid;
    logic             r_last;
    logic             r_err_0;
    logic             r_err_1;

    logic [WIDTH-1:0] w_head_0;
    logic [WIDTH-1:0] w_head_1;
    logic [CW-1:0]    w_cnt_0;
    logic [CW-1:0]    w_cnt_1;
    logic             w_ne_0;
    logic             w_ne_1;
    logic             w_load;
    logic             w_gnt;
    logic             w_gnt_ch;
    logic             w_pop_0;
    logic             w_pop_1;

    mux_rr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk(clk), .reset_L(reset_L), .i_push(push_0), .i_dat(data_in_0),
        .i_pop(w_pop_0), .o_head(w_head_0), .o_cnt(w_cnt_0)
    );

    mux_rr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk(clk), .reset_L(reset_L), .i_push(push_1), .i_dat(data_in_1),
        .i_pop(w_pop_1), .o_head(w_head_1), .o_cnt(w_cnt_1)
    );

    // Arbitration uses registered counts only, so a same-edge push is not yet visible.
    assign w_ne_0   = (w_cnt_0 != '0);
    assign w_ne_1   = (w_cnt_1 != '0);
    assign w_load   = !r_valid || ready_out;
    assign w_gnt    = w_load && (w_ne_0 || w_ne_1);
    assign w_gnt_ch = (w_ne_0 && w_ne_1) ? ~r_last : w_ne_1;
    assign w_pop_0  = w_gnt && !w_gnt_ch;
    assign w_pop_1  = w_gnt && w_gnt_ch;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_din_0 <= '0;
            r_din_1 <= '0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_load) begin
            if (w_gnt) begin
                r_state <= w_gnt_ch ? GRANT1 : GRANT0;
                r_valid <= 1'b1;
                r_sel   <= w_gnt_ch;
                r_last  <= w_gnt_ch;
                if (w_gnt_ch) r_din_1 <= w_head_1;
                else          r_din_0 <= w_head_0;
            end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_err_0 <= 1'b0;
            r_err_1 <= 1'b0;
        end else begin
            if (push_0 && full_0) r_err_0 <= 1'b1;
            if (push_1 && full_1) r_err_1 <= 1'b1;
        end
    end

    assign full_0    = (w_cnt_0 == CW'(DEPTH));
    assign full_1    = (w_cnt_1 == CW'(DEPTH));
    assign err_0     = r_err_0;
    assign err_1     = r_err_1;
    assign din_0     = r_din_0;
    assign din_1     = r_din_1;
    assign sel       = r_sel;
    assign valid_out = r_valid;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected words queued at push time, checked by a negedge monitor.
module tb_mux_rr_arbiter;
    logic       clk;
    logic       reset_L;
    logic       push_0;
    logic [3:0] data_in_0;
    logic       push_1;
    logic [3:0] data_in_1;
    logic       ready_out;
    logic       full_0;
    logic       full_1;
    logic       err_0;
    logic       err_1;
    logic [3:0] din_0;
    logic [3:0] din_1;
    logic       sel;
    logic       valid_out;

    typedef struct packed {
        logic       sel;
        logic [3:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] m_din0 = '0;
    logic [3:0] m_din1 = '0;

    mux_rr_arbiter #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .push_0(push_0), .data_in_0(data_in_0),
        .push_1(push_1), .data_in_1(data_in_1),
        .ready_out(ready_out),
        .full_0(full_0), .full_1(full_1), .err_0(err_0), .err_1(err_1),
        .din_0(din_0), .din_1(din_1), .sel(sel), .valid_out(valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic s, input logic [3:0] d);
        exp_t e;
        e.sel = s;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_sel"},   32'(sel),       32'd0);
        chk({tag, "_din_0"}, 32'(din_0),     32'd0);
        chk({tag, "_din_1"}, 32'(din_1),     32'd0);
        chk({tag, "_full_0"}, 32'(full_0),   32'd0);
        chk({tag, "_full_1"}, 32'(full_1),   32'd0);
        chk({tag, "_err_0"}, 32'(err_0),     32'd0);
        chk({tag, "_err_1"}, 32'(err_1),     32'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !valid_out) break;
            step();
        end
        chk({tag, "_drain_left"},  32'(exp_q.size()), 32'd0);
        chk({tag, "_drain_valid"}, 32'(valid_out),    32'd0);
    endtask

    // Monitor: one accepted word per negedge where valid_out && ready_out.
    always @(negedge clk) begin
        if (!reset_L) begin
            m_din0 = '0;
            m_din1 = '0;
        end else if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL mon_unexpected: got sel=%0d din_0=0x%0h din_1=0x%0h, expected no word", sel, din_0, din_1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_sel", 32'(sel), 32'(e.sel));
                if (e.sel) begin
                    chk("mon_din_1", 32'(din_1), 32'(e.dat));
                    chk("mon_din_0_hold", 32'(din_0), 32'(m_din0));
                    m_din1 = e.dat;
                end else begin
                    chk("mon_din_0", 32'(din_0), 32'(e.dat));
                    chk("mon_din_1_hold", 32'(din_1), 32'(m_din1));
                    m_din0 = e.dat;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b1; push_0 = 1'b0; push_1 = 1'b0;
        data_in_0 = '0; data_in_1 = '0; ready_out = 1'b0;
        step(); step();

        // T1: asynchronous reset, then idle
        #2 reset_L = 1'b0;
        #1 chk_reset_outputs("t1");
        step(); step();
        reset_L = 1'b1;
        ready_out = 1'b1;
        repeat (5) begin
            step();
            chk("t1_idle_valid", 32'(valid_out), 32'd0);
        end

        // T2: simultaneous push, tie goes to ch0 first
        push_0 = 1'b1; data_in_0 = 4'hA; push_1 = 1'b1; data_in_1 = 4'h6;
        exp_push(1'b0, 4'hA); exp_push(1'b1, 4'h6);
        step();
        push_0 = 1'b0; push_1 = 1'b0;
        chk("t2_valid_e1", 32'(valid_out), 32'd0);
        step();
        chk("t2_valid_e2", 32'(valid_out), 32'd1);
        chk("t2_sel_e2",   32'(sel),       32'd0);
        chk("t2_din_0_e2", 32'(din_0),     32'hA);
        step();
        chk("t2_valid_e3", 32'(valid_out), 32'd1);
        chk("t2_sel_e3",   32'(sel),       32'd1);
        chk("t2_din_1_e3", 32'(din_1),     32'h6);
        chk("t2_din_0_e3", 32'(din_0),     32'hA);
        step();
        chk("t2_valid_e4", 32'(valid_out), 32'd0);
        chk("t2_sel_e4",   32'(sel),       32'd1);
        chk("t2_din_1_e4", 32'(din_1),     32'h6);

        // T3: fill ch0 under stall, overflow push dropped
        ready_out = 1'b0;
        push_0 = 1'b1; data_in_0 = 4'h1; exp_push(1'b0, 4'h1);
        step();
        push_0 = 1'b0;
        step();
        chk("t3_first_valid", 32'(valid_out), 32'd1);
        chk("t3_first_din_0", 32'(din_0),     32'h1);
        for (int d = 2; d <= 5; d++) begin
            push_0 = 1'b1; data_in_0 = 4'(d); exp_push(1'b0, 4'(d));
            step();
            chk("t3_full_0", 32'(full_0), 32'(d == 5));
        end
        data_in_0 = 4'hF;
        step();
        push_0 = 1'b0;
        chk("t3_err_0",       32'(err_0),  32'd1);
        chk("t3_err_1",       32'(err_1),  32'd0);
        chk("t3_full_0_hold", 32'(full_0), 32'd1);
        chk("t3_din_0_stall", 32'(din_0),  32'h1);
        ready_out = 1'b1;
        drain("t3");
        chk("t3_err_0_sticky", 32'(err_0),  32'd1);
        chk("t3_full_0_after", 32'(full_0), 32'd0);

        // T4: 3-cycle stall holds outputs
        ready_out = 1'b0;
        push_1 = 1'b1; data_in_1 = 4'h7; exp_push(1'b1, 4'h7);
        step();
        data_in_1 = 4'h8; exp_push(1'b1, 4'h8);
        step();
        push_1 = 1'b0;
        chk("t4_valid", 32'(valid_out), 32'd1);
        chk("t4_sel",   32'(sel),       32'd1);
        chk("t4_din_1", 32'(din_1),     32'h7);
        repeat (3) begin
            step();
            chk("t4_hold_valid", 32'(valid_out), 32'd1);
            chk("t4_hold_sel",   32'(sel),       32'd1);
            chk("t4_hold_din_1", 32'(din_1),     32'h7);
            chk("t4_hold_din_0", 32'(din_0),     32'h5);
        end
        ready_out = 1'b1;
        step();
        chk("t4_adv_valid", 32'(valid_out), 32'd1);
        chk("t4_adv_din_1", 32'(din_1),     32'h8);
        drain("t4");

        // T5: ch1 only, back-to-back grants
        for (int d = 1; d <= 3; d++) begin
            push_1 = 1'b1; data_in_1 = 4'(d); exp_push(1'b1, 4'(d));
            step();
            if (d > 1) begin
                chk("t5_valid", 32'(valid_out), 32'd1);
                chk("t5_din_1", 32'(din_1),     32'(d - 1));
            end
        end
        push_1 = 1'b0;
        step();
        chk("t5_valid_last", 32'(valid_out), 32'd1);
        chk("t5_sel_last",   32'(sel),       32'd1);
        chk("t5_din_1_last", 32'(din_1),     32'h3);
        step();
        chk("t5_valid_end",  32'(valid_out), 32'd0);

        // T7: both channels busy, grants alternate
        push_0 = 1'b1; data_in_0 = 4'hB; push_1 = 1'b1; data_in_1 = 4'hD;
        exp_push(1'b0, 4'hB); exp_push(1'b1, 4'hD);
        exp_push(1'b0, 4'hC); exp_push(1'b1, 4'hE);
        step();
        data_in_0 = 4'hC; data_in_1 = 4'hE;
        step();
        push_0 = 1'b0; push_1 = 1'b0;
        chk("t7_sel_a", 32'(sel), 32'd0);
        step();
        chk("t7_sel_b", 32'(sel), 32'd1);
        step();
        chk("t7_sel_c", 32'(sel), 32'd0);
        step();
        chk("t7_sel_d", 32'(sel), 32'd1);
        drain("t7");

        // T6: reset mid-stream clears FIFOs, errors and arbitration history
        ready_out = 1'b0;
        for (int d = 0; d < 3; d++) begin
            push_0 = 1'b1; data_in_0 = 4'(1 + d);
            push_1 = 1'b1; data_in_1 = 4'(4 + d);
            step();
        end
        push_0 = 1'b0; push_1 = 1'b0;
        chk("t6_pre_valid", 32'(valid_out), 32'd1);
        chk("t6_pre_err_0", 32'(err_0),     32'd1);
        #2 reset_L = 1'b0;
        #1 chk_reset_outputs("t6");
        step();
        reset_L = 1'b1;
        ready_out = 1'b1;
        repeat (3) begin
            step();
            chk("t6_empty_valid", 32'(valid_out), 32'd0);
        end
        push_0 = 1'b1; data_in_0 = 4'h3; push_1 = 1'b1; data_in_1 = 4'hC;
        exp_push(1'b0, 4'h3); exp_push(1'b1, 4'hC);
        step();
        push_0 = 1'b0; push_1 = 1'b0;
        step();
        chk("t6_tie_sel",   32'(sel),   32'd0);
        chk("t6_tie_din_0", 32'(din_0), 32'h3);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
